vc_queue: RTL and testbench

//   Multi-virtual-channel input buffer for a mesh router port: NUM_VC independent

---
 rtl/vc_queue.sv | 150 +++++++++++++++
 tb/tb_vc_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_queue.sv
// ============================================================================
// vc_queue
// ----------------------------------------------------------------------------
// Multi-virtual-channel input buffer for one mesh router port. NUM_VC
// independent circular FIFOs of DEPTH flits each share a single write port.
// The head of every VC is presented combinationally (first-word fall-through).
//
// Flit bit numbering: the link numbers flit bits MSB-first, so the link's
// "bit 0" (the valid / push-request flag) is the most significant bit of the
// descending vectors used here, i.e. i_data_in[PL-1]. A flit value such as
// 8'h81 therefore carries its valid flag in bit 7.
//
// Ports
//   i_clk                  rising-edge clock
//   i_rst_n                asynchronous active-low reset
//   i_data_in   [PL]       write flit; MSB set means push request
//   i_vc_in     [VC_B]     target VC of the write flit
//   i_shift_signal [NUM_VC] per-VC pop request
//   o_data_out  [NUM_VC*PL] head of VC v at [v*PL +: PL], zero while empty
//   o_availability_signal [NUM_VC] VC v can accept a push this cycle
//   o_almost_full [NUM_VC] occupancy of VC v >= AF_THRESH
//   o_count     [NUM_VC*CNT_B] occupancy of VC v at [v*CNT_B +: CNT_B]
//   o_drop_error           sticky: a push request was refused
// ============================================================================
module vc_queue #(
    parameter int PL        = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_VC    = 2,
    parameter int AF_THRESH = 3,
    localparam int VC_B     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_B    = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [PL-1:0]           i_data_in,
    input  logic [VC_B-1:0]         i_vc_in,
    input  logic [NUM_VC-1:0]       i_shift_signal,
    output logic [NUM_VC*PL-1:0]    o_data_out,
    output logic [NUM_VC-1:0]       o_availability_signal,
    output logic [NUM_VC-1:0]       o_almost_full,
    output logic [NUM_VC*CNT_B-1:0] o_count,
    output logic                    o_drop_error
);

    // Pointers only ever hold 0..DEPTH-1; DEPTH >= 2 keeps this at least 1 bit.
    localparam int PTR_B = $clog2(DEPTH);

    logic              w_valid;
    logic [NUM_VC-1:0] w_avail;
    logic              w_targetAvail;
    logic              w_dropNow;
    logic              r_dropError;

    // Advance a circular pointer. DEPTH need not be a power of two, so the
    // wrap is an explicit compare against the last slot rather than a
    // natural binary overflow.
    function automatic logic [PTR_B-1:0] nextPtr(input logic [PTR_B-1:0] p);
        if (p == PTR_B'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_valid = i_data_in[PL-1];

    // Per-VC storage, pointers and occupancy.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [PL-1:0]    r_mem [DEPTH];
        logic [PTR_B-1:0] r_rdPtr;
        logic [PTR_B-1:0] r_wrPtr;
        logic [CNT_B-1:0] r_count;
        logic             w_full;
        logic             w_empty;
        logic             w_push;
        logic             w_pop;

        assign w_full  = (r_count == CNT_B'(DEPTH));
        assign w_empty = (r_count == '0);

        // A full VC still accepts a flit when its head leaves in the same
        // cycle, which is what lets the link stream at full rate.
        assign w_avail[v] = !w_full || i_shift_signal[v];

        assign w_push = w_valid && (32'(i_vc_in) == v) && w_avail[v];

        // Popping an empty VC is silently ignored; a simultaneous push into
        // an empty VC therefore just stores the flit.
        assign w_pop  = i_shift_signal[v] && !w_empty;

        // Storage, pointer and count update. On push+pop the count stays put
        // and both pointers move; at count==1 the new flit becomes the head.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                if (w_push) begin
                    r_mem[r_wrPtr] <= i_data_in;
                    r_wrPtr        <= nextPtr(r_wrPtr);
                end
                if (w_pop) begin
                    r_rdPtr <= nextPtr(r_rdPtr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Head flit is forced to zero while empty so downstream logic sees a
        // cleared valid flag rather than a stale entry.
        assign o_data_out[v*PL +: PL]    = w_empty ? '0 : r_mem[r_rdPtr];
        assign o_count[v*CNT_B +: CNT_B] = r_count;
        assign o_almost_full[v]          = (32'(r_count) >= AF_THRESH);
    end

    assign o_availability_signal = w_avail;

    // Look up the availability of the addressed VC. An out-of-range VC
    // number matches nothing and so reads as unavailable, which turns it
    // into a drop as well.
    always_comb begin
        w_targetAvail = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (32'(i_vc_in) == v) begin
                w_targetAvail = w_avail[v];
            end
        end
    end

    assign w_dropNow = w_valid && !w_targetAvail;

    // Sticky drop indicator; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dropError <= 1'b0;
        end else if (w_dropNow) begin
            r_dropError <= 1'b1;
        end
    end

    assign o_drop_error = r_dropError;

endmodule

// File: tb/tb_vc_queue.sv
// ============================================================================
// tb_vc_queue
// ----------------------------------------------------------------------------
// Bench for vc_queue (PL=8, DEPTH=3, NUM_VC=2, AF_THRESH=2). The driver keeps
// a queue-based model of every VC; for each cycle it pushes the expected
// output snapshot, plus any flit it expects to be popped, into scoreboard
// queues. An independent monitor samples the DUT on the falling edge and
// compares against what it pops from those queues.
// ============================================================================
module tb_vc_queue;

    localparam int PL        = 8;
    localparam int DEPTH     = 3;
    localparam int NUM_VC    = 2;
    localparam int AF_THRESH = 2;
    localparam int VC_B      = 1;
    localparam int CNT_B     = 2;

    logic                    clk;
    logic                    rst_n;
    logic [PL-1:0]           dataIn;
    logic [VC_B-1:0]         vcIn;
    logic [NUM_VC-1:0]       shiftSignal;
    logic [NUM_VC*PL-1:0]    dataOut;
    logic [NUM_VC-1:0]       availabilitySignal;
    logic [NUM_VC-1:0]       almostFull;
    logic [NUM_VC*CNT_B-1:0] count;
    logic                    dropError;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NUM_VC*PL-1:0]    dout;
        logic [NUM_VC*CNT_B-1:0] cnt;
        logic [NUM_VC-1:0]       avail;
        logic [NUM_VC-1:0]       af;
        logic                    drop;
    } exp_t;

    exp_t          expQ[$];
    logic [PL-1:0] popQ[NUM_VC][$];
    logic [PL-1:0] mq[NUM_VC][$];
    logic          mdlDrop = 1'b0;

    vc_queue #(
        .PL(PL), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AF_THRESH(AF_THRESH)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_data_in             (dataIn),
        .i_vc_in               (vcIn),
        .i_shift_signal        (shiftSignal),
        .o_data_out            (dataOut),
        .o_availability_signal (availabilitySignal),
        .o_almost_full         (almostFull),
        .o_count               (count),
        .o_drop_error          (dropError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs given the model contents and the shift inputs
    // currently applied.
    function automatic exp_t snapshot(input logic [NUM_VC-1:0] sh);
        exp_t e;
        e = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            e.dout[v*PL +: PL]    = (mq[v].size() > 0) ? mq[v][0] : '0;
            e.cnt[v*CNT_B +: CNT_B] = CNT_B'(mq[v].size());
            e.avail[v]            = (mq[v].size() < DEPTH) || sh[v];
            e.af[v]               = (mq[v].size() >= AF_THRESH);
        end
        e.drop = mdlDrop;
        return e;
    endfunction

    // Drive one cycle of inputs, record expectations, then advance the model
    // across the coming clock edge.
    task automatic applyStimulus(input logic [PL-1:0] din, input int vc,
                                 input logic [NUM_VC-1:0] sh);
        logic [NUM_VC-1:0] availNow;
        @(posedge clk);
        #2;
        dataIn      = din;
        vcIn        = VC_B'(vc);
        shiftSignal = sh;
        expQ.push_back(snapshot(sh));
        for (int v = 0; v < NUM_VC; v++) begin
            availNow[v] = (mq[v].size() < DEPTH) || sh[v];
        end
        for (int v = 0; v < NUM_VC; v++) begin
            if (sh[v] && mq[v].size() > 0) begin
                popQ[v].push_back(mq[v].pop_front());
            end
        end
        if (din[PL-1]) begin
            if (vc >= NUM_VC || !availNow[vc]) begin
                mdlDrop = 1'b1;
            end else begin
                mq[vc].push_back(din);
            end
        end
    endtask

    // Assert reset between clock edges and expect the outputs to clear
    // immediately, without waiting for an edge.
    task automatic pulseReset();
        @(posedge clk);
        #2;
        dataIn      = '0;
        vcIn        = '0;
        shiftSignal = '0;
        rst_n       = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            mq[v].delete();
        end
        mdlDrop = 1'b0;
        #1;
        checkOutput("rst_data_out", 32'(dataOut), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_avail", 32'(availabilitySignal), 32'h3);
        checkOutput("rst_almost_full", 32'(almostFull), 32'h0);
        checkOutput("rst_drop_error", 32'(dropError), 32'h0);
        #1;
        rst_n = 1'b1;
        expQ.push_back(snapshot('0));
    endtask

    // Monitor: compare every recorded snapshot, and every flit the DUT
    // presents while it is being popped, against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("data_out", 32'(dataOut), 32'(e.dout));
                checkOutput("count", 32'(count), 32'(e.cnt));
                checkOutput("avail", 32'(availabilitySignal), 32'(e.avail));
                checkOutput("almost_full", 32'(almostFull), 32'(e.af));
                checkOutput("drop_error", 32'(dropError), 32'(e.drop));
                for (int v = 0; v < NUM_VC; v++) begin
                    if (shiftSignal[v] && dataOut[v*PL + PL - 1]) begin
                        if (popQ[v].size() == 0) begin
                            checkOutput("pop_unexpected", 32'(dataOut[v*PL +: PL]), 32'h0);
                        end else begin
                            checkOutput("pop_flit", 32'(dataOut[v*PL +: PL]),
                                        32'(popQ[v].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [PL-1:0]     din;
        logic [NUM_VC-1:0] sh;
        rst_n       = 1'b0;
        dataIn      = '0;
        vcIn        = '0;
        shiftSignal = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Idle after reset
        applyStimulus(8'h00, 0, 2'b00);
        applyStimulus(8'h00, 0, 2'b00);

        // Fill VC1, VC0 untouched
        applyStimulus(8'h81, 1, 2'b00);
        applyStimulus(8'h83, 1, 2'b00);
        applyStimulus(8'h85, 1, 2'b00);
        applyStimulus(8'h00, 0, 2'b00);

        // Drop at full, then push+pop at full and drain across the wrap
        applyStimulus(8'h87, 1, 2'b00);
        applyStimulus(8'h89, 1, 2'b10);
        applyStimulus(8'h00, 0, 2'b10);
        applyStimulus(8'h00, 0, 2'b10);
        applyStimulus(8'h00, 0, 2'b10);
        applyStimulus(8'h00, 0, 2'b00);

        // Push VC0 while popping VC1
        applyStimulus(8'h95, 1, 2'b00);
        applyStimulus(8'h97, 1, 2'b00);
        applyStimulus(8'hA1, 0, 2'b10);
        applyStimulus(8'h00, 0, 2'b00);

        // Push+pop into empty VC0, pop on empty VC1, invalid flit to VC1
        applyStimulus(8'h00, 0, 2'b11);
        applyStimulus(8'h00, 0, 2'b10);
        applyStimulus(8'h91, 0, 2'b01);
        applyStimulus(8'h00, 0, 2'b10);
        applyStimulus(8'h11, 1, 2'b00);
        applyStimulus(8'h00, 0, 2'b00);

        // Fill both VCs, asynchronous reset, then reuse
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(PL'(8'hB1 + 2 * i), 0, 2'b00);
            applyStimulus(PL'(8'hD1 + 2 * i), 1, 2'b00);
        end
        pulseReset();
        applyStimulus(8'hC1, 0, 2'b00);
        applyStimulus(8'h00, 0, 2'b00);

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(63) == 0) begin
                pulseReset();
            end else begin
                din        = PL'($urandom);
                din[PL-1]  = ($urandom_range(3) != 0);
                for (int v = 0; v < NUM_VC; v++) begin
                    sh[v] = ($urandom_range(3) == 0);
                end
                applyStimulus(din, int'($urandom_range(NUM_VC - 1)), sh);
            end
        end

        applyStimulus(8'h00, 0, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("expq_drain", 32'(expQ.size()), 32'h0);
        for (int v = 0; v < NUM_VC; v++) begin
            checkOutput("popq_drain", 32'(popQ[v].size()), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
